alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/riscv_alu_pkg.sv | 43 ++++
 rtl/mdu_iter.sv | 86 ++++++++
 rtl/alu_exec.sv | 168 ++++++++++++++++
 tb/tb_alu_exec.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_alu_pkg.sv
// Shared definitions for the RV32I/M execute stage.
//   op_e    : internal operation after instruction decode
//   state_e : execute FSM states
//   F3_*    : funct3 encodings (base integer and M extension)
package riscv_alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_e;

  // base integer funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // M-extension funct3
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  function automatic logic is_mul_op(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic is_div_op(input op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath, one bit per cycle on magnitudes.
//   i_start : load operands (a, b, op taken from the undelayed inputs)
//   i_step  : perform one iteration
//   i_op_q  : op latched by the top, selects the step type and the result
//   o_res   : result formed from the values this step produces, so the top
//             can register it on the final step edge
module mdu_iter
  import riscv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  op_e             i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_step,
  input  op_e             i_op_q,
  output logic [XLEN-1:0] o_res
);

  // mul: r_hi = partial product high half, r_lo = multiplier shifting out
  // div: r_hi = partial remainder, r_lo = dividend shifting out / quotient in
  logic [XLEN-1:0] r_hi, r_lo, r_mc, r_a;
  logic            r_neg, r_rneg, r_dz;

  logic            w_sa, w_sb;
  logic [XLEN-1:0] w_ma, w_mb;
  logic [XLEN:0]   w_sum, w_rs;
  logic [XLEN-1:0] w_sub, w_hi_n, w_lo_n, w_q, w_r;
  logic            w_ge;
  logic [2*XLEN-1:0] w_prod;

  always_comb begin
    w_sa = (i_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) & i_a[XLEN-1];
    w_sb = (i_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) & i_b[XLEN-1];
    w_ma = w_sa ? -i_a : i_a;
    w_mb = w_sb ? -i_b : i_b;
  end

  always_comb begin
    w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mc} : '0);
    w_rs  = {r_hi, r_lo[XLEN-1]};
    w_ge  = (w_rs >= {1'b0, r_mc});
    w_sub = XLEN'(w_rs - {1'b0, r_mc});
    if (is_mul_op(i_op_q)) begin
      w_hi_n = w_sum[XLEN:1];
      w_lo_n = {w_sum[0], r_lo[XLEN-1:1]};
    end else begin
      w_hi_n = w_ge ? w_sub : w_rs[XLEN-1:0];
      w_lo_n = {r_lo[XLEN-2:0], w_ge};
    end
    w_prod = r_neg ? -{w_hi_n, w_lo_n} : {w_hi_n, w_lo_n};
    w_q    = r_neg  ? -w_lo_n : w_lo_n;
    w_r    = r_rneg ? -w_hi_n : w_hi_n;
    // divide by zero naturally yields an all-ones magnitude quotient, but the
    // sign fixup would corrupt it, so it is overridden here
    case (i_op_q)
      OP_MUL:                      o_res = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: o_res = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             o_res = r_dz ? '1 : w_q;
      OP_REM, OP_REMU:             o_res = r_dz ? r_a : w_r;
      default:                     o_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0; r_lo <= '0; r_mc <= '0; r_a <= '0;
      r_neg <= 1'b0; r_rneg <= 1'b0; r_dz <= 1'b0;
    end else if (i_start) begin
      r_hi   <= '0;
      r_lo   <= is_mul_op(i_op) ? w_mb : w_ma;
      r_mc   <= is_mul_op(i_op) ? w_ma : w_mb;
      r_a    <= i_a;
      r_neg  <= w_sa ^ w_sb;
      r_rneg <= w_sa;
      r_dz   <= (i_b == '0);
    end else if (i_step) begin
      r_hi <= w_hi_n;
      r_lo <= w_lo_n;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// RV32I/M execute unit with valid/ready handshakes on both sides.
//   in_valid/in_ready   : operation offer/accept (accepted only in IDLE)
//   alu_op, op5, funct3, funct7_5, funct7_0 : decode inputs
//   a, b                : operands (shift amount = low log2(XLEN) bits of b)
//   out_valid/out_ready : result handshake
//   result, zero        : registered result and result==0 flag
//   busy                : high while a multiply/divide iterates
// Single-cycle ops complete one cycle after acceptance, M ops XLEN+1 cycles.
module alu_exec
  import riscv_alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit MDU_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic            op5,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN);

  state_e          r_state;
  op_e             r_op;
  logic [CW-1:0]   r_cnt;
  logic            r_valid, r_zero;
  logic [XLEN-1:0] r_result;

  op_e             w_op;
  logic [XLEN-1:0] w_alu, w_mdu_res;
  logic [SHW-1:0]  w_sh;
  logic            w_start, w_step;

  // decode
  always_comb begin
    w_op = OP_ADD;
    case (alu_op)
      2'b01: w_op = OP_SUB;
      2'b10: begin
        if (MDU_EN && op5 && funct7_0) begin
          case (funct3)
            F3_MUL:    w_op = OP_MUL;
            F3_MULH:   w_op = OP_MULH;
            F3_MULHSU: w_op = OP_MULHSU;
            F3_MULHU:  w_op = OP_MULHU;
            F3_DIV:    w_op = OP_DIV;
            F3_DIVU:   w_op = OP_DIVU;
            F3_REM:    w_op = OP_REM;
            default:   w_op = OP_REMU;
          endcase
        end else begin
          case (funct3)
            F3_ADD:  w_op = (op5 && funct7_5) ? OP_SUB : OP_ADD;
            F3_SLL:  w_op = OP_SLL;
            F3_SLT:  w_op = OP_SLT;
            F3_SLTU: w_op = OP_SLTU;
            F3_XOR:  w_op = OP_XOR;
            F3_SR:   w_op = funct7_5 ? OP_SRA : OP_SRL;
            F3_OR:   w_op = OP_OR;
            default: w_op = OP_AND;
          endcase
        end
      end
      default: w_op = OP_ADD;
    endcase
  end

  // single-cycle datapath, evaluated on the raw inputs at acceptance
  always_comb begin
    w_sh = b[SHW-1:0];
    case (w_op)
      OP_SUB:  w_alu = a - b;
      OP_SLL:  w_alu = a << w_sh;
      OP_SLT:  w_alu = XLEN'($signed(a) < $signed(b));
      OP_SLTU: w_alu = XLEN'(a < b);
      OP_XOR:  w_alu = a ^ b;
      OP_SRL:  w_alu = a >> w_sh;
      OP_SRA:  w_alu = $signed(a) >>> w_sh;
      OP_OR:   w_alu = a | b;
      OP_AND:  w_alu = a & b;
      default: w_alu = a + b;
    endcase
  end

  assign w_start = (r_state == ST_IDLE) && in_valid;
  assign w_step  = (r_state == ST_MUL) || (r_state == ST_DIV);

  generate
    if (MDU_EN) begin : g_mdu
      mdu_iter #(.XLEN(XLEN)) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .i_start(w_start),
        .i_op   (w_op),
        .i_a    (a),
        .i_b    (b),
        .i_step (w_step),
        .i_op_q (r_op),
        .o_res  (w_mdu_res)
      );
    end else begin : g_nomdu
      assign w_mdu_res = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_ADD;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_op  <= w_op;
          r_cnt <= '0;
          if (is_mul_op(w_op))      r_state <= ST_MUL;
          else if (is_div_op(w_op)) r_state <= ST_DIV;
          else begin
            r_state  <= ST_DONE;
            r_result <= w_alu;
            r_zero   <= (w_alu == '0);
            r_valid  <= 1'b1;
          end
        end
        ST_MUL, ST_DIV: begin
          // the last iteration and the result capture share one edge
          if (r_cnt == CW'(XLEN-1)) begin
            r_state  <= ST_DONE;
            r_result <= w_mdu_res;
            r_zero   <= (w_mdu_res == '0);
            r_valid  <= 1'b1;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: if (out_ready) begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = w_step;
  assign out_valid = r_valid;
  assign result    = r_result;
  assign zero      = r_zero;

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [1:0]  alu_op;
  logic        op5, funct7_5, funct7_0;
  logic [2:0]  funct3;
  logic [31:0] a, b, result;
  logic        out_valid, out_ready, zero, busy;

  alu_exec #(.XLEN(32), .MDU_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .op5(op5), .funct3(funct3), .funct7_5(funct7_5),
    .funct7_0(funct7_0), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { string tag; logic [31:0] v; } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", tag, act, exp);
    else n_pass++;
  endtask

  // scoreboard: compare on every handshaken output
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_out", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "_res"}, result, e.v);
        chk({e.tag, "_zero"}, zero, e.v == 0);
      end
    end
  end

  function automatic logic [31:0] model(input logic m, input logic [2:0] f3,
                                        input logic f75, input logic [31:0] x, y);
    longint sx, sy, uy;
    logic [63:0] p;
    logic [31:0] r;
    sx = longint'($signed(x)); sy = longint'($signed(y)); uy = longint'({32'b0, y});
    r = '0;
    if (m) begin
      case (f3)
        3'd0: begin p = sx * sy; r = p[31:0]; end
        3'd1: begin p = sx * sy; r = p[63:32]; end
        3'd2: begin p = sx * uy; r = p[63:32]; end
        3'd3: begin p = {32'b0, x} * {32'b0, y}; r = p[63:32]; end
        3'd4: r = (y == 0) ? 32'hFFFFFFFF : 32'(sx / sy);
        3'd5: r = (y == 0) ? 32'hFFFFFFFF : x / y;
        3'd6: r = (y == 0) ? x : 32'(sx % sy);
        default: r = (y == 0) ? x : x % y;
      endcase
    end else begin
      case (f3)
        3'd0: r = f75 ? x - y : x + y;
        3'd1: r = x << y[4:0];
        3'd2: r = {31'b0, $signed(x) < $signed(y)};
        3'd3: r = {31'b0, x < y};
        3'd4: r = x ^ y;
        3'd5: r = f75 ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
        3'd6: r = x | y;
        default: r = x & y;
      endcase
    end
    return r;
  endfunction

  // issue one op, push its expectation, measure latency and busy cycles
  task automatic do_op(input string tag, input logic [1:0] aop, input logic o5,
                       input logic [2:0] f3, input logic f75, input logic f70,
                       input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ev, input int lat);
    int n, cyc, nb;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk({tag, "_rdy"}, in_ready, 1);
    alu_op = aop; op5 = o5; funct3 = f3; funct7_5 = f75; funct7_0 = f70;
    a = av; b = bv; in_valid = 1'b1;
    sb.push_back('{tag, ev});
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    cyc = 1; nb = 0;
    while (!out_valid && cyc < 100) begin
      if (busy) nb++;
      @(negedge clk); cyc++;
    end
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_busy"}, nb, lat - 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 0; op5 = 0; funct3 = 0; funct7_5 = 0; funct7_0 = 0; a = 0; b = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // directed single-cycle ops
    do_op("sub_rtype", 2'b10, 1, 3'b000, 1, 0, 5, 7, 32'hFFFFFFFE, 1);
    do_op("sra",  2'b10, 1, 3'b101, 1, 0, 32'h80000000, 4, 32'hF8000000, 1);
    do_op("srl",  2'b10, 1, 3'b101, 0, 0, 32'h80000000, 4, 32'h08000000, 1);
    do_op("add_zero", 2'b00, 0, 3'b000, 0, 0, 1, 32'hFFFFFFFF, 0, 1);
    do_op("aop01_sub", 2'b01, 0, 3'b111, 0, 0, 10, 3, 7, 1);
    do_op("aop11_add", 2'b11, 1, 3'b100, 1, 1, 10, 3, 13, 1);
    do_op("slt",  2'b10, 1, 3'b010, 0, 0, 32'hFFFFFFFF, 1, 1, 1);
    do_op("sltu", 2'b10, 1, 3'b011, 0, 0, 32'hFFFFFFFF, 1, 0, 1);
    do_op("sll_shamt", 2'b10, 1, 3'b001, 0, 0, 1, 32'h21, 2, 1);
    do_op("itype_not_m", 2'b10, 0, 3'b000, 1, 1, 5, 7, 12, 1);

    // multiply / divide
    do_op("mulh",  2'b10, 1, 3'b001, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 33);
    do_op("mulhu", 2'b10, 1, 3'b011, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    do_op("mul",   2'b10, 1, 3'b000, 0, 1, 32'hFFFFFFFD, 7, 32'hFFFFFFEB, 33);
    do_op("div",   2'b10, 1, 3'b100, 0, 1, 32'hFFFFFFF9, 2, 32'hFFFFFFFD, 33);
    do_op("rem",   2'b10, 1, 3'b110, 0, 1, 32'hFFFFFFF9, 2, 32'hFFFFFFFF, 33);
    do_op("divu0", 2'b10, 1, 3'b101, 0, 1, 7, 0, 32'hFFFFFFFF, 33);
    do_op("remu0", 2'b10, 1, 3'b111, 0, 1, 7, 0, 7, 33);
    do_op("div_ovf", 2'b10, 1, 3'b100, 0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
    do_op("rem_ovf", 2'b10, 1, 3'b110, 0, 1, 32'h80000000, 32'hFFFFFFFF, 0, 33);

    // output stall: result held, new offers ignored
    @(posedge clk); #1 out_ready = 1'b0;
    do_op("div_stall", 2'b10, 1, 3'b100, 0, 1, 100, 7, 14, 33);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 in_valid = 1'b1; a = 32'h123; b = 32'h456; funct3 = 3'b000;
      @(negedge clk);
      chk("stall_result", result, 14);
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);

    // one bubble between consume and next accept
    do_op("pre_bubble", 2'b00, 0, 3'b000, 0, 0, 40, 2, 42, 1);
    alu_op = 2'b00; op5 = 0; funct3 = 0; funct7_5 = 0; funct7_0 = 0;
    a = 2; b = 3; in_valid = 1'b1;
    sb.push_back('{"bubble_op", 32'd5});
    chk("bubble_rdy_done", in_ready, 0);
    @(negedge clk);
    chk("bubble_rdy_idle", in_ready, 1);
    chk("bubble_no_out", out_valid, 0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bubble_out", out_valid, 1);

    // random mix against the model
    for (int i = 0; i < 10; i++) begin
      logic m, f75;
      logic [2:0] f3;
      logic [31:0] x, y;
      m = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
      f75 = m ? 1'b0 : 1'($urandom_range(0, 1));
      x = $urandom; y = (i % 4 == 3) ? 32'd0 : $urandom;
      do_op($sformatf("rnd%0d", i), 2'b10, 1, f3, f75, m, x, y,
            model(m, f3, f75, x, y), m ? 33 : 1);
    end

    // reset in the middle of a multiply
    @(negedge clk);
    cnt = 0;
    while (!in_ready && cnt < 100) begin @(negedge clk); cnt++; end
    alu_op = 2'b10; op5 = 1; funct3 = 3'b000; funct7_5 = 0; funct7_0 = 1;
    a = 3; b = 4; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("mid_mul_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    cnt = 0;
    repeat (40) begin @(negedge clk); if (out_valid) cnt++; end
    chk("abort_no_output", cnt, 0);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
